alu_control_sequencer: RTL and testbench

Control-step sequencer that drives the DataPath strobes for instruction fetch and execution of register-to-register ALU instructions. It is the producer side of the DataPath control interface. Every strobe the datapath consumes (PCout, MARin, Zin, Yin, register select, ALU_control, shift count, and the rest) comes from this block, one control step per clock. It sits beside DataPath and reads back only the IR contents and a memory-ready flag.

---
 rtl/alu_seq_pkg.sv | 45 ++++
 rtl/alu_seq_decode.sv | 35 +++
 rtl/alu_control_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types, opcodes and IR field positions for the ALU control sequencer
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_FAULT = 4'd8
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_ROR  = 5'h09;
    localparam logic [4:0] OP_ROL  = 5'h0A;
    localparam logic [4:0] OP_SHL  = 5'h0B;
    localparam logic [4:0] OP_SHR  = 5'h0D;
    localparam logic [4:0] OP_SHRA = 5'h0E;
    localparam logic [4:0] OP_MUL  = 5'h0F;
    localparam logic [4:0] OP_DIV  = 5'h10;
    localparam logic [4:0] OP_NEG  = 5'h11;
    localparam logic [4:0] OP_NOT  = 5'h12;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;
    localparam int IMM_HI = 4;
    localparam int IMM_LO = 0;

    function automatic logic [7:0] alu_code(input logic [4:0] op);
        return {3'b000, op};
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational opcode classifier
// Ports:
//   opcode_i    in  5 : opcode field of IR
//   is_binary   out 1 : ADD/SUB/AND/OR
//   is_unary    out 1 : NEG/NOT
//   is_shift    out 1 : ROR/ROL/SHL/SHR/SHRA
//   is_muldiv   out 1 : MUL/DIV (classified regardless of build configuration)
//   is_illegal  out 1 : any other opcode
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic       is_binary,
    output logic       is_unary,
    output logic       is_shift,
    output logic       is_muldiv,
    output logic       is_illegal
);

    always_comb begin
        is_binary  = 1'b0;
        is_unary   = 1'b0;
        is_shift   = 1'b0;
        is_muldiv  = 1'b0;
        is_illegal = 1'b0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR:           is_binary  = 1'b1;
            OP_NEG, OP_NOT:                          is_unary   = 1'b1;
            OP_ROR, OP_ROL, OP_SHL, OP_SHR, OP_SHRA: is_shift   = 1'b1;
            OP_MUL, OP_DIV:                          is_muldiv  = 1'b1;
            default:                                 is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - control-step sequencer driving DataPath strobes for fetch and ALU execute
// Build option: ALU_SEQ_MULDIV_EN enables MUL/DIV (T6, HIin/LOin/Zhighout); otherwise MUL/DIV fault.
// Ports:
//   clock, clear        : clock, synchronous active-low reset
//   run                 : level, keep fetching instructions
//   ir[IR_W]            : IR contents from DataPath
//   mem_ready           : memory read data valid
//   PCout..LOin         : DataPath strobes
//   Gra/Grb/Grc/Rin/Rout: register select-and-encode controls
//   ALU_control[8]      : {3'b000, opcode} in ALU steps
//   shift_count[5]      : immediate count in shift T4
//   done                : final-step pulse
//   illegal             : set while in FAULT
module alu_control_sequencer
    import alu_seq_pkg::*;
#(
    parameter int IR_W = 32
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [IR_W-1:0] ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            MARin,
    output logic            IncPC,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            PCin,
    output logic            read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            HIin,
    output logic            LOin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic [7:0]      ALU_control,
    output logic [4:0]      shift_count,
    output logic            done,
    output logic            illegal
);

    state_e     state_q;
    logic       t1_wait_q;  // set after the first T1 cycle so PCin/Zlowout drop while waiting
    logic [4:0] opcode;
    logic       is_binary, is_unary, is_shift, is_muldiv, is_illegal;
    logic       muldiv_op;
    logic       bad_op;
    state_e     fin_state;

    assign opcode = ir[OPC_HI:OPC_LO];

    // Register numbers are taken by DataPath's select-and-encode directly from IR.
    logic unused_ir;
    assign unused_ir = ^ir[RA_HI:IMM_HI+1];

    alu_seq_decode u_decode (
        .opcode_i   (opcode),
        .is_binary  (is_binary),
        .is_unary   (is_unary),
        .is_shift   (is_shift),
        .is_muldiv  (is_muldiv),
        .is_illegal (is_illegal)
    );

`ifdef ALU_SEQ_MULDIV_EN
    assign muldiv_op = is_muldiv;
`else
    assign muldiv_op = 1'b0;
`endif
    assign bad_op    = is_illegal | (is_muldiv & ~muldiv_op);
    assign fin_state = run ? ST_T0 : ST_IDLE;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            t1_wait_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  if (run) state_q <= ST_T0;
                ST_T0: begin
                    state_q   <= ST_T1;
                    t1_wait_q <= 1'b0;
                end
                ST_T1: begin
                    if (mem_ready) begin
                        state_q   <= ST_T2;
                        t1_wait_q <= 1'b0;
                    end else begin
                        t1_wait_q <= 1'b1;
                    end
                end
                ST_T2:    state_q <= ST_T3;
                ST_T3:    state_q <= bad_op ? ST_FAULT : ST_T4;
                ST_T4:    state_q <= is_unary ? fin_state : ST_T5;
                ST_T5:    state_q <= muldiv_op ? ST_T6 : fin_state;
                ST_T6:    state_q <= fin_state;
                ST_FAULT: state_q <= ST_FAULT;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0;
        Zlowout = 1'b0; Zhighout = 1'b0; PCin = 1'b0; read = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; done = 1'b0; illegal = 1'b0;
        ALU_control = 8'h00;
        shift_count = 5'd0;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            ST_T1: begin
                read    = 1'b1;
                MDRin   = 1'b1;
                Zlowout = ~t1_wait_q;
                PCin    = ~t1_wait_q;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                if (is_binary || is_shift) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_unary) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                    ALU_control = alu_code(opcode);
                end else if (muldiv_op) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
            end
            ST_T4: begin
                if (is_binary) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                    ALU_control = alu_code(opcode);
                end else if (is_shift) begin
                    Zin = 1'b1;
                    ALU_control = alu_code(opcode);
                    shift_count = ir[IMM_HI:IMM_LO];
                end else if (is_unary) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end else if (muldiv_op) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                    ALU_control = alu_code(opcode);
                end
            end
            ST_T5: begin
`ifdef ALU_SEQ_MULDIV_EN
                if (muldiv_op) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                end
`else
                Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_T6: begin
                Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
            end
`endif
            ST_FAULT: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - directed self-checking bench for alu_control_sequencer
module tb_alu_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        mem_ready = 1'b0;
    logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, read, MDRin, MDRout, IRin, Yin;
    logic HIin, LOin, Gra, Grb, Grc, Rin, Rout, done, illegal;
    logic [7:0] ALU_control;
    logic [4:0] shift_count;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alu_control_sequencer #(.IR_W(32)) dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .PCin(PCin), .read(read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .ALU_control(ALU_control),
        .shift_count(shift_count), .done(done), .illegal(illegal)
    );

    logic [20:0] strobes;
    logic [33:0] obs;
    assign strobes = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, read, MDRin, MDRout,
                      IRin, Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout, done, illegal};
    assign obs = {strobes, ALU_control, shift_count};

    localparam logic [20:0] M_PCOUT = 21'd1 << 20, M_MARIN = 21'd1 << 19, M_INCPC = 21'd1 << 18;
    localparam logic [20:0] M_ZIN = 21'd1 << 17, M_ZLO = 21'd1 << 16, M_ZHI = 21'd1 << 15;
    localparam logic [20:0] M_PCIN = 21'd1 << 14, M_READ = 21'd1 << 13, M_MDRIN = 21'd1 << 12;
    localparam logic [20:0] M_MDROUT = 21'd1 << 11, M_IRIN = 21'd1 << 10, M_YIN = 21'd1 << 9;
    localparam logic [20:0] M_HIIN = 21'd1 << 8, M_LOIN = 21'd1 << 7, M_GRA = 21'd1 << 6;
    localparam logic [20:0] M_GRB = 21'd1 << 5, M_GRC = 21'd1 << 4, M_RIN = 21'd1 << 3;
    localparam logic [20:0] M_ROUT = 21'd1 << 2, M_DONE = 21'd1 << 1, M_ILL = 21'd1;

    localparam logic [20:0] S_T0   = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [20:0] S_T1   = M_ZLO | M_PCIN | M_READ | M_MDRIN;
    localparam logic [20:0] S_T1W  = M_READ | M_MDRIN;
    localparam logic [20:0] S_T2   = M_MDROUT | M_IRIN;
    localparam logic [20:0] S_WB   = M_ZLO | M_GRA | M_RIN | M_DONE;

    function automatic logic [33:0] ex(input logic [20:0] s, input logic [7:0] a, input logic [4:0] c);
        return {s, a, c};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = 32'h6A180004;
        step();
        step();
        checks++;
        if (obs !== 34'd0) begin
            failures++;
            $display("FAIL reset: got %h expected %h", obs, 34'd0);
        end
        run = 1'b0;
        clear = 1'b1;
        step();
        checks++;
        if (obs !== 34'd0) begin
            failures++;
            $display("FAIL reset_idle: got %h expected %h", obs, 34'd0);
        end
    endtask

    task automatic test_shr();
        logic [33:0] e [0:6];
        e[0] = ex(S_T0, 8'h00, 5'd0);
        e[1] = ex(S_T1, 8'h00, 5'd0);
        e[2] = ex(S_T2, 8'h00, 5'd0);
        e[3] = ex(M_GRB | M_ROUT | M_YIN, 8'h00, 5'd0);
        e[4] = ex(M_ZIN, 8'h0D, 5'd4);
        e[5] = ex(S_WB, 8'h00, 5'd0);
        e[6] = 34'd0;
        ir = 32'h6A180004; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) run = 1'b0;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL shr[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [33:0] e [0:7];
        e[0] = ex(S_T0, 8'h00, 5'd0);
        e[1] = ex(S_T1, 8'h00, 5'd0);
        e[2] = ex(S_T1W, 8'h00, 5'd0);
        e[3] = ex(S_T1W, 8'h00, 5'd0);
        e[4] = ex(S_T1W, 8'h00, 5'd0);
        e[5] = ex(S_T2, 8'h00, 5'd0);
        e[6] = ex(M_GRB | M_ROUT | M_YIN, 8'h00, 5'd0);
        e[7] = ex(M_GRC | M_ROUT | M_ZIN, 8'h01, 5'd0);
        ir = 32'h0A1A8000; mem_ready = 1'b0; run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) run = 1'b0;
            if (i == 4) mem_ready = 1'b1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL mem_wait[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
        // reset during T4 of ADD: straight to IDLE, no done pulse afterwards
        clear = 1'b0;
        step();
        checks++;
        if (obs !== 34'd0) begin
            failures++;
            $display("FAIL clear_in_t4: got %h expected %h", obs, 34'd0);
        end
        clear = 1'b1;
        step();
        checks++;
        if (obs !== 34'd0) begin
            failures++;
            $display("FAIL after_clear_t4: got %h expected %h", obs, 34'd0);
        end
    endtask

    task automatic test_illegal();
        logic [33:0] e [0:5];
        e[0] = ex(S_T0, 8'h00, 5'd0);
        e[1] = ex(S_T1, 8'h00, 5'd0);
        e[2] = ex(S_T2, 8'h00, 5'd0);
        e[3] = 34'd0;
        e[4] = ex(M_ILL, 8'h00, 5'd0);
        e[5] = ex(M_ILL, 8'h00, 5'd0);
        ir = 32'hF8000000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL illegal[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
        run = 1'b0;
        clear = 1'b0;
        step();
        clear = 1'b1;
        checks++;
        if (obs !== 34'd0) begin
            failures++;
            $display("FAIL illegal_clear: got %h expected %h", obs, 34'd0);
        end
    endtask

    task automatic test_muldiv();
        logic [33:0] e [0:7];
        int n;
        e[0] = ex(S_T0, 8'h00, 5'd0);
        e[1] = ex(S_T1, 8'h00, 5'd0);
        e[2] = ex(S_T2, 8'h00, 5'd0);
`ifdef ALU_SEQ_MULDIV_EN
        n = 8;
        e[3] = ex(M_GRA | M_ROUT | M_YIN, 8'h00, 5'd0);
        e[4] = ex(M_GRB | M_ROUT | M_ZIN, 8'h0F, 5'd0);
        e[5] = ex(M_ZLO | M_LOIN, 8'h00, 5'd0);
        e[6] = ex(M_ZHI | M_HIIN | M_DONE, 8'h00, 5'd0);
        e[7] = 34'd0;
`else
        n = 6;
        e[3] = 34'd0;
        e[4] = ex(M_ILL, 8'h00, 5'd0);
        e[5] = ex(M_ILL, 8'h00, 5'd0);
        e[6] = 34'd0;
        e[7] = 34'd0;
`endif
        ir = 32'h79180000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 0) run = 1'b0;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL muldiv[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
        clear = 1'b0;
        step();
        clear = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [33:0] e [0:10];
        int dones;
        for (int k = 0; k < 2; k++) begin
            e[k*5+0] = ex(S_T0, 8'h00, 5'd0);
            e[k*5+1] = ex(S_T1, 8'h00, 5'd0);
            e[k*5+2] = ex(S_T2, 8'h00, 5'd0);
            e[k*5+3] = ex(M_GRB | M_ROUT | M_ZIN, 8'h12, 5'd0);
            e[k*5+4] = ex(S_WB, 8'h00, 5'd0);
        end
        e[10] = 34'd0;
        dones = 0;
        ir = 32'h90900000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i == 5) run = 1'b0;
            if (done === 1'b1) dones++;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, e[i]);
            end
        end
        checks++;
        if (dones !== 2) begin
            failures++;
            $display("FAIL back_to_back_dones: got %0d expected %0d", dones, 2);
        end
    endtask

    initial begin
        test_reset();
        test_shr();
        test_mem_wait();
        test_illegal();
        test_muldiv();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
